quot_bcd: RTL and testbench

QUOT_BCD -- requirements
Module: quot_bcd

---
 rtl/quot_bcd.sv | 148 ++++++++++++++
 tb/tb_quot_bcd.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/quot_bcd.sv
// Converts an unsigned fixed-point quotient into BCD integer and fractional digits.
// Integer part uses serial double-dabble; the fraction is expanded digit by digit via repeated multiply-by-10.
module quot_bcd #(
    parameter int N           = 14,
    parameter int DEC         = 4,
    parameter int INT_DIGITS  = 4,
    parameter int FRAC_DIGITS = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N-1:0]               q_in,
    input  logic                       q_valid,
    input  logic                       clr_ovr,
    output logic                       busy,
    output logic [4*INT_DIGITS-1:0]    bcd_int,
    output logic [4*FRAC_DIGITS-1:0]   bcd_frac,
    output logic                       sat,
    output logic                       out_valid,
    output logic                       overrun
);

    localparam int IW  = N - DEC;
    // Scratch holds every digit the integer part can reach, so saturation is exact.
    localparam int SD0 = (IW + 2) / 3 + 1;
    localparam int SD  = (SD0 > INT_DIGITS) ? SD0 : INT_DIGITS;
    localparam int CW  = $clog2(IW + FRAC_DIGITS + 1);
    localparam logic [DEC+3:0] TEN = (DEC+4)'(10);

    typedef enum logic [1:0] {IDLE, CONV_INT, CONV_FRAC, DONE} state_t;

    state_t                     state_q, state_d;
    logic [IW-1:0]              int_q, int_d;
    logic [DEC-1:0]             f_q, f_d;
    logic [4*SD-1:0]            dig_q, dig_d;
    logic [4*FRAC_DIGITS-1:0]   fd_q, fd_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [4*INT_DIGITS-1:0]    bcd_int_q;
    logic [4*FRAC_DIGITS-1:0]   bcd_frac_q;
    logic                       sat_q, out_valid_q, overrun_q;
    logic                       load, ovr_evt, sat_c;
    logic [4*SD-1:0]            adj;
    logic [DEC+3:0]             prod;

    function automatic logic [4*SD-1:0] dabble_adj(input logic [4*SD-1:0] d);
        logic [4*SD-1:0] r;
        r = d;
        for (int i = 0; i < SD; i++) begin
            if (d[4*i +: 4] >= 4'd5) r[4*i +: 4] = d[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign prod = {4'b0000, f_q} * TEN;
    assign adj  = dabble_adj(dig_q);

    always_comb begin
        sat_c = 1'b0;
        for (int i = INT_DIGITS; i < SD; i++) begin
            if (dig_q[4*i +: 4] != 4'd0) sat_c = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        int_d   = int_q;
        f_d     = f_q;
        dig_d   = dig_q;
        fd_d    = fd_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        ovr_evt = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                load = (state_q == DONE);
                if (q_valid) begin
                    int_d   = q_in[N-1:DEC];
                    f_d     = q_in[DEC-1:0];
                    dig_d   = '0;
                    fd_d    = '0;
                    cnt_d   = '0;
                    state_d = CONV_INT;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV_INT: begin
                ovr_evt = q_valid;
                dig_d   = {adj[4*SD-2:0], int_q[IW-1]};
                int_d   = int_q << 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(IW - 1)) begin
                    cnt_d   = '0;
                    state_d = CONV_FRAC;
                end
            end
            CONV_FRAC: begin
                ovr_evt = q_valid;
                fd_d    = (fd_q << 4) | (4*FRAC_DIGITS)'(prod[DEC+3:DEC]);
                f_d     = prod[DEC-1:0];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(FRAC_DIGITS - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            int_q       <= '0;
            f_q         <= '0;
            dig_q       <= '0;
            fd_q        <= '0;
            cnt_q       <= '0;
            bcd_int_q   <= '0;
            bcd_frac_q  <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            int_q       <= int_d;
            f_q         <= f_d;
            dig_q       <= dig_d;
            fd_q        <= fd_d;
            cnt_q       <= cnt_d;
            out_valid_q <= load;
            // A drop in the same cycle as a clear must still leave overrun set.
            overrun_q   <= ovr_evt | (overrun_q & ~clr_ovr);
            if (load) begin
                bcd_int_q  <= sat_c ? {INT_DIGITS{4'h9}} : dig_q[4*INT_DIGITS-1:0];
                bcd_frac_q <= fd_q;
                sat_q      <= sat_c;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign bcd_int   = bcd_int_q;
    assign bcd_frac  = bcd_frac_q;
    assign sat       = sat_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_quot_bcd.sv
// Directed bench for quot_bcd: a reference model fills scoreboards at stimulus time;
// a negedge monitor pops them on every out_valid, for a 4-digit and a 3-digit instance.
module tb_quot_bcd;

    typedef struct packed {
        logic [15:0] i;
        logic [7:0]  f;
        logic        s;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [13:0] q_in = '0;
    logic        q_valid = 1'b0;
    logic        clr_ovr = 1'b0;

    logic        busy, sat, out_valid, overrun;
    logic [15:0] bcd_int;
    logic [7:0]  bcd_frac;
    logic        busy3, sat3, out_valid3, overrun3;
    logic [11:0] bcd_int3;
    logic [7:0]  bcd_frac3;

    int   tests = 0;
    int   fails = 0;
    exp_t q4[$];
    exp_t q3[$];

    quot_bcd dut (
        .clk(clk), .reset_n(reset_n), .q_in(q_in), .q_valid(q_valid), .clr_ovr(clr_ovr),
        .busy(busy), .bcd_int(bcd_int), .bcd_frac(bcd_frac), .sat(sat),
        .out_valid(out_valid), .overrun(overrun)
    );

    quot_bcd #(.INT_DIGITS(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .q_in(q_in), .q_valid(q_valid), .clr_ovr(clr_ovr),
        .busy(busy3), .bcd_int(bcd_int3), .bcd_frac(bcd_frac3), .sat(sat3),
        .out_valid(out_valid3), .overrun(overrun3)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [13:0] q, input int digits);
        exp_t e;
        int   ip, f, lim, v;
        ip  = int'(q[13:4]);
        f   = int'(q[3:0]);
        lim = 1;
        for (int k = 0; k < digits; k++) lim = lim * 10;
        e.s = (ip >= lim);
        v   = e.s ? lim - 1 : ip;
        e.i = '0;
        for (int k = 0; k < digits; k++) begin
            e.i[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        e.f = '0;
        for (int k = 0; k < 2; k++) begin
            f   = f * 10;
            e.f = {e.f[3:0], 4'(f / 16)};
            f   = f % 16;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            check("out_expected", 32'(q4.size() != 0), 32'd1);
            if (q4.size() != 0) begin
                exp_t e;
                e = q4.pop_front();
                check("bcd_int", 32'(bcd_int), 32'(e.i));
                check("bcd_frac", 32'(bcd_frac), 32'(e.f));
                check("sat", 32'(sat), 32'(e.s));
            end
        end
        if (reset_n && out_valid3) begin
            check("out_expected3", 32'(q3.size() != 0), 32'd1);
            if (q3.size() != 0) begin
                exp_t e;
                e = q3.pop_front();
                check("bcd_int3", 32'(bcd_int3), 32'(e.i));
                check("bcd_frac3", 32'(bcd_frac3), 32'(e.f));
                check("sat3", 32'(sat3), 32'(e.s));
            end
        end
    end

    task automatic send(input logic [13:0] v, input bit push);
        @(negedge clk);
        q_in    = v;
        q_valid = 1'b1;
        if (push) begin
            q4.push_back(model(v, 4));
            q3.push_back(model(v, 3));
        end
        @(posedge clk);
        #1 q_valid = 1'b0;
    endtask

    task automatic wait_out(input int lat);
        int n;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1 n++;
            if (out_valid) break;
        end
        check("latency", 32'(n), 32'(lat));
        @(posedge clk);
        #1 check("out_valid_pulse", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        check("rst_bcd_int", 32'(bcd_int), 32'd0);
        check("rst_bcd_frac", 32'(bcd_frac), 32'd0);
        @(negedge clk) reset_n = 1'b1;

        send(14'h00A8, 1'b1);
        wait_out(13);
        repeat (3) @(posedge clk);
        #1;
        check("a8_int_hold", 32'(bcd_int), 32'h0010);
        check("a8_frac_hold", 32'(bcd_frac), 32'h50);

        send(14'h3FFF, 1'b1);
        wait_out(13);
        check("max_int", 32'(bcd_int), 32'h1023);
        check("max_frac", 32'(bcd_frac), 32'h93);
        check("max_sat", 32'(sat), 32'd0);
        check("max_int3", 32'(bcd_int3), 32'h999);
        check("max_sat3", 32'(sat3), 32'd1);

        send(14'h0001, 1'b1);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("busy_cycles", 32'(n), 32'd13);
        check("lsb_int", 32'(bcd_int), 32'h0000);
        check("lsb_frac", 32'(bcd_frac), 32'h06);
        repeat (3) @(posedge clk);

        send(14'h0123, 1'b1);
        repeat (4) @(posedge clk);
        send(14'h0456, 1'b0);
        check("overrun_set", 32'(overrun), 32'd1);
        wait_out(8);
        repeat (20) @(posedge clk);
        #1 check("overrun_sticky", 32'(overrun), 32'd1);
        @(negedge clk) clr_ovr = 1'b1;
        @(posedge clk);
        #1 clr_ovr = 1'b0;
        check("overrun_clr", 32'(overrun), 32'd0);

        send(14'h0200, 1'b1);
        repeat (12) @(posedge clk);
        send(14'h0333, 1'b1);
        check("b2b_first_out", 32'(out_valid), 32'd1);
        wait_out(13);
        check("b2b_overrun", 32'(overrun), 32'd0);
        check("b2b_drained", 32'(q4.size()), 32'd0);

        send(14'h0155, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        q4.delete();
        q3.delete();
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_overrun", 32'(overrun), 32'd0);
        check("mid_sat", 32'(sat), 32'd0);
        check("mid_bcd_int", 32'(bcd_int), 32'd0);
        check("mid_bcd_frac", 32'(bcd_frac), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        repeat (20) @(posedge clk);
        send(14'h0208, 1'b1);
        wait_out(13);
        check("post_rst_int", 32'(bcd_int), 32'h0032);
        check("post_rst_frac", 32'(bcd_frac), 32'h50);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(q4.size() + q3.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
